// File: rtl/spi_slave_param.sv
// Parametrised SPI slave: configurable width, SPI mode and synchroniser depth.
// Ports:
//   clk, rst_n            system clock, async active-low reset
//   SCLK, SS_n, MOSI      SPI pins from the master
//   MISO, miso_oe         slave data out (Z when deselected) and its enable
//   tx_data, wrt          response word and its one-cycle write strobe
//   rsp_rdy               response buffer holds an unsent word
//   cmd_rcvd, cmd_rdy     last committed command and its valid flag
//   cmd_ack               core consumed cmd_rcvd
//   frame_err             one-cycle pulse on a wrong-length frame
//   overrun, underrun     sticky error flags, cleared by clr_err
module spi_slave_param #(
    parameter int DATA_W      = 16,
    parameter bit CPOL        = 1'b0,
    parameter bit CPHA        = 1'b1,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              SCLK,
    input  logic              SS_n,
    input  logic              MOSI,
    output logic              MISO,
    output logic              miso_oe,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              wrt,
    output logic              rsp_rdy,
    output logic [DATA_W-1:0] cmd_rcvd,
    output logic              cmd_rdy,
    input  logic              cmd_ack,
    output logic              frame_err,
    output logic              overrun,
    output logic              underrun,
    input  logic              clr_err
);

    localparam int CW = $clog2(DATA_W + 2);
    localparam logic [CW-1:0] CNT_FULL = CW'(DATA_W);
    localparam logic [CW-1:0] CNT_MAX  = CW'(DATA_W + 1);

    typedef enum logic {
        IDLE,
        XFER
    } state_t;

    state_t state, state_nxt;

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] ss_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic [SYNC_STAGES-1:0] prime;
    logic                   sclk_q;
    logic                   sclk_s;
    logic                   ss_s;
    logic                   mosi_s;
    logic                   lead_edge;
    logic                   trail_edge;
    logic                   sample_edge;
    logic                   change_edge;
    logic                   armed;

    logic                   load;
    logic                   finish;
    logic                   in_xfer;

    logic [DATA_W-1:0]      tx_buf;
    logic [DATA_W-1:0]      shift_tx;
    logic [DATA_W-1:0]      shift_rx;
    logic [CW-1:0]          bit_cnt;
    logic                   skip_chg;
    logic                   fin_q;
    logic                   len_ok_q;
    logic                   commit;
    logic                   drop;

    // Synchronisers. prime tracks how far real pin samples have
    // propagated, so the reset value of ss_sync cannot arm the slave.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync <= {SYNC_STAGES{CPOL}};
            ss_sync   <= '1;
            mosi_sync <= '0;
            prime     <= '0;
            sclk_q    <= CPOL;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
            ss_sync   <= {ss_sync[SYNC_STAGES-2:0], SS_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
            prime     <= {prime[SYNC_STAGES-2:0], 1'b1};
            sclk_q    <= sclk_s;
        end
    end

    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign ss_s   = ss_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];

    assign lead_edge   = (sclk_q == CPOL) && (sclk_s != CPOL);
    assign trail_edge  = (sclk_q != CPOL) && (sclk_s == CPOL);
    assign sample_edge = CPHA ? trail_edge : lead_edge;
    assign change_edge = CPHA ? lead_edge : trail_edge;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed <= 1'b0;
        end else if (prime[SYNC_STAGES-1] && ss_s) begin
            armed <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (armed && !ss_s) state_nxt = XFER;
            XFER: if (ss_s) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        load    = 1'b0;
        finish  = 1'b0;
        in_xfer = 1'b0;
        miso_oe = 1'b0;
        unique case (state)
            IDLE: load = armed && !ss_s;
            XFER: begin
                in_xfer = 1'b1;
                miso_oe = 1'b1;
                finish  = ss_s;
            end
            default: ;
        endcase
    end

    assign MISO = miso_oe ? shift_tx[DATA_W-1] : 1'bz;

    // In CPHA=1 the MSB is already on MISO at load, so the first
    // change edge of the frame must not shift it away.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_tx <= '0;
            shift_rx <= '0;
            bit_cnt  <= '0;
            skip_chg <= 1'b0;
        end else if (load) begin
            shift_tx <= tx_buf;
            bit_cnt  <= '0;
            skip_chg <= CPHA;
        end else if (in_xfer) begin
            if (sample_edge) begin
                shift_rx <= {shift_rx[DATA_W-2:0], mosi_s};
                if (bit_cnt != CNT_MAX) bit_cnt <= bit_cnt + 1'b1;
            end
            if (change_edge) begin
                if (skip_chg) skip_chg <= 1'b0;
                else shift_tx <= {shift_tx[DATA_W-2:0], 1'b0};
            end
        end
    end

    // A write coinciding with a load leaves the new word pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_buf  <= '0;
            rsp_rdy <= 1'b0;
        end else begin
            if (wrt) tx_buf <= tx_data;
            if (wrt) rsp_rdy <= 1'b1;
            else if (load) rsp_rdy <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fin_q    <= 1'b0;
            len_ok_q <= 1'b0;
        end else begin
            fin_q    <= finish;
            len_ok_q <= (bit_cnt == CNT_FULL);
        end
    end

    // An ack in the commit cycle frees the slot for the new word.
    assign commit = fin_q && len_ok_q && (!cmd_rdy || cmd_ack);
    assign drop   = fin_q && len_ok_q && cmd_rdy && !cmd_ack;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_rcvd  <= '0;
            cmd_rdy   <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            frame_err <= fin_q && !len_ok_q;
            if (commit) begin
                cmd_rcvd <= shift_rx;
                cmd_rdy  <= 1'b1;
            end else if (cmd_ack) begin
                cmd_rdy  <= 1'b0;
            end
            overrun  <= drop | (overrun & ~clr_err);
            underrun <= (load & ~rsp_rdy) | (underrun & ~clr_err);
        end
    end

endmodule

// File: tb/tb_spi_slave_param.sv
// Bench for spi_slave_param: three instances (mode 0/16b, mode 3/16b,
// mode 2/12b with 3 sync stages) driven by a task-level SPI master.
module tb_spi_slave_param;

    localparam int H = 6;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  sclk, ss_n, mosi, wrt, ack, clr;
    logic [15:0] tx0, tx1;
    logic [11:0] tx2;
    wire         miso0, miso1, miso2;
    wire  [2:0]  oe, rsp, rdy, ferr, ovr, und;
    wire  [15:0] cmd0, cmd1;
    wire  [11:0] cmd2;

    int pass_cnt = 0;
    int total_cnt = 0;

    logic [31:0] m_buf [3];
    logic [31:0] m_cmd [3];
    bit          m_rsp [3];
    bit          m_rdy [3];
    bit          m_ovr [3];
    bit          m_und [3];
    int          m_ferr [3] = '{0, 0, 0};
    int          ferr_seen [3] = '{0, 0, 0};

    always #5 clk = ~clk;

    spi_slave_param #(.DATA_W(16), .CPOL(1'b0), .CPHA(1'b0), .SYNC_STAGES(2)) u0 (
        .clk(clk), .rst_n(rst_n), .SCLK(sclk[0]), .SS_n(ss_n[0]), .MOSI(mosi[0]),
        .MISO(miso0), .miso_oe(oe[0]), .tx_data(tx0), .wrt(wrt[0]), .rsp_rdy(rsp[0]),
        .cmd_rcvd(cmd0), .cmd_rdy(rdy[0]), .cmd_ack(ack[0]), .frame_err(ferr[0]),
        .overrun(ovr[0]), .underrun(und[0]), .clr_err(clr[0]));

    spi_slave_param #(.DATA_W(16), .CPOL(1'b1), .CPHA(1'b1), .SYNC_STAGES(2)) u1 (
        .clk(clk), .rst_n(rst_n), .SCLK(sclk[1]), .SS_n(ss_n[1]), .MOSI(mosi[1]),
        .MISO(miso1), .miso_oe(oe[1]), .tx_data(tx1), .wrt(wrt[1]), .rsp_rdy(rsp[1]),
        .cmd_rcvd(cmd1), .cmd_rdy(rdy[1]), .cmd_ack(ack[1]), .frame_err(ferr[1]),
        .overrun(ovr[1]), .underrun(und[1]), .clr_err(clr[1]));

    spi_slave_param #(.DATA_W(12), .CPOL(1'b1), .CPHA(1'b0), .SYNC_STAGES(3)) u2 (
        .clk(clk), .rst_n(rst_n), .SCLK(sclk[2]), .SS_n(ss_n[2]), .MOSI(mosi[2]),
        .MISO(miso2), .miso_oe(oe[2]), .tx_data(tx2), .wrt(wrt[2]), .rsp_rdy(rsp[2]),
        .cmd_rcvd(cmd2), .cmd_rdy(rdy[2]), .cmd_ack(ack[2]), .frame_err(ferr[2]),
        .overrun(ovr[2]), .underrun(und[2]), .clr_err(clr[2]));

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) if (ferr[k] === 1'b1) ferr_seen[k]++;
    end

    function automatic int w_of(int i);
        return (i == 2) ? 12 : 16;
    endfunction

    function automatic logic cpol_of(int i);
        return (i == 0) ? 1'b0 : 1'b1;
    endfunction

    function automatic logic cpha_of(int i);
        return (i == 1) ? 1'b1 : 1'b0;
    endfunction

    function automatic int s_of(int i);
        return (i == 2) ? 3 : 2;
    endfunction

    function automatic logic [31:0] msk(int i, logic [31:0] v);
        logic [63:0] m;
        m = (64'd1 << w_of(i)) - 64'd1;
        return v & m[31:0];
    endfunction

    function automatic logic [31:0] get_cmd(int i);
        case (i)
            0: return {16'h0, cmd0};
            1: return {16'h0, cmd1};
            default: return {20'h0, cmd2};
        endcase
    endfunction

    function automatic logic get_miso(int i);
        case (i)
            0: return miso0;
            1: return miso1;
            default: return miso2;
        endcase
    endfunction

    task automatic set_tx(input int i, input logic [31:0] v);
        case (i)
            0: tx0 = v[15:0];
            1: tx1 = v[15:0];
            default: tx2 = v[11:0];
        endcase
    endtask

    // Reference model: what one whole frame does to the slave's state.
    task automatic m_frame(input int i, input logic [31:0] m, input int n,
                           output logic [31:0] exp_rx);
        exp_rx = m_buf[i];
        if (!m_rsp[i]) m_und[i] = 1'b1;
        m_rsp[i] = 1'b0;
        if (n != w_of(i)) m_ferr[i]++;
        else if (m_rdy[i]) m_ovr[i] = 1'b1;
        else begin
            m_cmd[i] = msk(i, m);
            m_rdy[i] = 1'b1;
        end
    endtask

    task automatic m_reset();
        for (int k = 0; k < 3; k++) begin
            m_buf[k] = '0; m_cmd[k] = '0; m_rsp[k] = 0;
            m_rdy[k] = 0; m_ovr[k] = 0; m_und[k] = 0;
        end
    endtask

    task automatic write_tx(input int i, input logic [31:0] v);
        set_tx(i, v);
        wrt[i] = 1'b1;
        @(negedge clk);
        wrt[i] = 1'b0;
        m_buf[i] = msk(i, v);
        m_rsp[i] = 1'b1;
    endtask

    task automatic do_ack(input int i);
        ack[i] = 1'b1;
        @(negedge clk);
        ack[i] = 1'b0;
        m_rdy[i] = 1'b0;
    endtask

    task automatic do_clr(input int i);
        clr[i] = 1'b1;
        @(negedge clk);
        clr[i] = 1'b0;
        m_ovr[i] = 1'b0;
        m_und[i] = 1'b0;
    endtask

    // SPI master. rdy_early/rdy_late sample cmd_rdy S+1 and S+2 clk
    // edges after SS_n rises; ack_end pulses cmd_ack into the commit cycle.
    task automatic spi_xfer(input int i, input logic [31:0] m, input int n,
                            input bit hold, input bit wr_start,
                            input logic [31:0] wr_val, input bit ack_end,
                            output logic [31:0] rx, output logic rdy_early,
                            output logic rdy_late);
        logic pol, pha, bv;
        pol = cpol_of(i);
        pha = cpha_of(i);
        rx = '0;
        rdy_early = 1'b0;
        rdy_late = 1'b0;
        ss_n[i] = 1'b0;
        if (wr_start) begin
            repeat (s_of(i)) @(negedge clk);
            set_tx(i, wr_val);
            wrt[i] = 1'b1;
            @(negedge clk);
            wrt[i] = 1'b0;
        end
        repeat (H) @(negedge clk);
        for (int b = 0; b < n; b++) begin
            bv = m[n-1-b];
            if (!pha) begin
                mosi[i] = bv;
                repeat (H) @(negedge clk);
                sclk[i] = ~pol;
                rx = {rx[30:0], get_miso(i)};
                repeat (H) @(negedge clk);
                sclk[i] = pol;
            end else begin
                repeat (H) @(negedge clk);
                sclk[i] = ~pol;
                mosi[i] = bv;
                repeat (H) @(negedge clk);
                rx = {rx[30:0], get_miso(i)};
                sclk[i] = pol;
            end
        end
        repeat (H) @(negedge clk);
        if (!hold) begin
            ss_n[i] = 1'b1;
            repeat (s_of(i) + 1) @(negedge clk);
            rdy_early = rdy[i];
            if (ack_end) ack[i] = 1'b1;
            @(negedge clk);
            ack[i] = 1'b0;
            rdy_late = rdy[i];
            repeat (4) @(negedge clk);
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            total_cnt++;
            if ({oe[i], rsp[i], rdy[i], ferr[i], ovr[i], und[i]} !== 6'b0)
                $display("FAIL reset_flags[%0d] got %b want 000000", i,
                         {oe[i], rsp[i], rdy[i], ferr[i], ovr[i], und[i]});
            else pass_cnt++;
            total_cnt++;
            if (get_cmd(i) !== 32'h0)
                $display("FAIL reset_cmd[%0d] got %h want 0", i, get_cmd(i));
            else pass_cnt++;
        end
    endtask

    task automatic test_mode(input int i);
        logic [31:0] rx, exp;
        logic e, l;
        write_tx(i, 32'hA5C3);
        total_cnt++;
        if (rsp[i] !== 1'b1) $display("FAIL mode_rsp_set[%0d] got %b want 1", i, rsp[i]);
        else pass_cnt++;
        spi_xfer(i, 32'h1234, 16, 0, 0, 0, 0, rx, e, l);
        m_frame(i, 32'h1234, 16, exp);
        total_cnt++;
        if (rx !== exp) $display("FAIL mode_miso[%0d] got %h want %h", i, rx, exp);
        else pass_cnt++;
        total_cnt++;
        if ({e, l} !== 2'b01)
            $display("FAIL mode_latency[%0d] got %b want 01", i, {e, l});
        else pass_cnt++;
        total_cnt++;
        if (get_cmd(i) !== m_cmd[i])
            $display("FAIL mode_cmd[%0d] got %h want %h", i, get_cmd(i), m_cmd[i]);
        else pass_cnt++;
        total_cnt++;
        if ({rsp[i], und[i], oe[i]} !== {m_rsp[i], m_und[i], 1'b0})
            $display("FAIL mode_flags[%0d] got %b want %b", i,
                     {rsp[i], und[i], oe[i]}, {m_rsp[i], m_und[i], 1'b0});
        else pass_cnt++;
        do_ack(i);
        total_cnt++;
        if (rdy[i] !== 1'b0) $display("FAIL mode_ack[%0d] got %b want 0", i, rdy[i]);
        else pass_cnt++;
    endtask

    task automatic test_width();
        logic [31:0] rx, exp;
        logic e, l;
        write_tx(2, 32'h5A6);
        spi_xfer(2, 32'hABC, 12, 0, 0, 0, 0, rx, e, l);
        m_frame(2, 32'hABC, 12, exp);
        total_cnt++;
        if ({get_cmd(2), l, rx} !== {m_cmd[2], 1'b1, exp})
            $display("FAIL width12 got cmd=%h rdy=%b rx=%h want cmd=%h rdy=1 rx=%h",
                     get_cmd(2), l, rx, m_cmd[2], exp);
        else pass_cnt++;
        spi_xfer(2, 32'h1F0F, 13, 0, 0, 0, 0, rx, e, l);
        m_frame(2, 32'h1F0F, 13, exp);
        total_cnt++;
        if (ferr_seen[2] !== m_ferr[2])
            $display("FAIL width13_ferr got %0d want %0d", ferr_seen[2], m_ferr[2]);
        else pass_cnt++;
        total_cnt++;
        if ({rdy[2], get_cmd(2)} !== {1'b1, m_cmd[2]})
            $display("FAIL width13_cmd got %b/%h want 1/%h", rdy[2], get_cmd(2), m_cmd[2]);
        else pass_cnt++;
        do_ack(2);
    endtask

    task automatic test_overrun();
        logic [31:0] rx, exp;
        logic e, l;
        write_tx(1, 32'h0001);
        spi_xfer(1, 32'h00FF, 16, 0, 0, 0, 0, rx, e, l);
        m_frame(1, 32'h00FF, 16, exp);
        spi_xfer(1, 32'hFF00, 16, 0, 0, 0, 0, rx, e, l);
        m_frame(1, 32'hFF00, 16, exp);
        total_cnt++;
        if ({get_cmd(1), ovr[1], rdy[1]} !== {m_cmd[1], m_ovr[1], 1'b1})
            $display("FAIL overrun got cmd=%h ovr=%b want cmd=%h ovr=%b",
                     get_cmd(1), ovr[1], m_cmd[1], m_ovr[1]);
        else pass_cnt++;
        do_clr(1);
        total_cnt++;
        if (ovr[1] !== 1'b0) $display("FAIL overrun_clr got %b want 0", ovr[1]);
        else pass_cnt++;
        do_ack(1);
    endtask

    task automatic test_underrun();
        logic [31:0] rx, exp;
        logic e, l;
        do_clr(0);
        spi_xfer(0, 32'h0F0F, 16, 0, 0, 0, 0, rx, e, l);
        m_frame(0, 32'h0F0F, 16, exp);
        total_cnt++;
        if ({und[0], rx} !== {m_und[0], exp})
            $display("FAIL underrun got und=%b rx=%h want und=%b rx=%h",
                     und[0], rx, m_und[0], exp);
        else pass_cnt++;
        do_ack(0);
        do_clr(0);
        write_tx(0, 32'h1111);
        spi_xfer(0, 32'h3C3C, 16, 0, 1, 32'h2222, 0, rx, e, l);
        m_frame(0, 32'h3C3C, 16, exp);
        m_buf[0] = 32'h2222;
        m_rsp[0] = 1'b1;
        total_cnt++;
        if ({rx, rsp[0], und[0]} !== {exp, 1'b1, m_und[0]})
            $display("FAIL wrt_at_load got rx=%h rsp=%b und=%b want rx=%h rsp=1 und=%b",
                     rx, rsp[0], und[0], exp, m_und[0]);
        else pass_cnt++;
        do_ack(0);
        spi_xfer(0, 32'h0, 16, 0, 0, 0, 0, rx, e, l);
        m_frame(0, 32'h0, 16, exp);
        total_cnt++;
        if (rx !== exp) $display("FAIL wrt_at_load_next got %h want %h", rx, exp);
        else pass_cnt++;
        do_ack(0);
    endtask

    task automatic test_ack_commit();
        logic [31:0] rx, exp;
        logic e, l;
        do_clr(1);
        spi_xfer(1, 32'hBEEF, 16, 0, 0, 0, 0, rx, e, l);
        m_frame(1, 32'hBEEF, 16, exp);
        spi_xfer(1, 32'hCAFE, 16, 0, 0, 0, 1, rx, e, l);
        m_rdy[1] = 1'b0;
        m_frame(1, 32'hCAFE, 16, exp);
        total_cnt++;
        if ({l, get_cmd(1), ovr[1]} !== {1'b1, m_cmd[1], m_ovr[1]})
            $display("FAIL ack_commit got rdy=%b cmd=%h ovr=%b want 1/%h/%b",
                     l, get_cmd(1), ovr[1], m_cmd[1], m_ovr[1]);
        else pass_cnt++;
        do_ack(1);
    endtask

    task automatic test_reset_mid();
        logic [31:0] rx, exp;
        logic e, l;
        int f0;
        f0 = ferr_seen[0];
        write_tx(0, 32'h7777);
        spi_xfer(0, 32'h55, 7, 1, 0, 0, 0, rx, e, l);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        m_reset();
        spi_xfer(0, 32'h1AB, 9, 0, 0, 0, 0, rx, e, l);
        total_cnt++;
        if ({e, l, rdy[0], get_cmd(0)} !== 35'h0)
            $display("FAIL reset_mid_commit got rdy=%b cmd=%h want 0/0", l, get_cmd(0));
        else pass_cnt++;
        total_cnt++;
        if (ferr_seen[0] !== f0)
            $display("FAIL reset_mid_ferr got %0d want %0d", ferr_seen[0], f0);
        else pass_cnt++;
        spi_xfer(0, 32'h6E6E, 16, 0, 0, 0, 0, rx, e, l);
        m_frame(0, 32'h6E6E, 16, exp);
        total_cnt++;
        if ({get_cmd(0), l, rx, und[0]} !== {m_cmd[0], 1'b1, exp, m_und[0]})
            $display("FAIL reset_mid_next got cmd=%h rx=%h und=%b want %h/%h/%b",
                     get_cmd(0), rx, und[0], m_cmd[0], exp, m_und[0]);
        else pass_cnt++;
        do_ack(0);
    endtask

    task automatic test_random();
        logic [31:0] rx, exp, m, wv;
        logic e, l, e_exp;
        int i, n, r;
        bit ws, ae;
        for (int t = 0; t < 24; t++) begin
            i = $urandom_range(2);
            if ($urandom_range(1) == 1) write_tx(i, $urandom);
            if ($urandom_range(1) == 1) do_ack(i);
            if ($urandom_range(4) == 0) do_clr(i);
            r = $urandom_range(9);
            n = (r == 0) ? w_of(i) - 1 : (r == 1) ? w_of(i) + 1 : w_of(i);
            m = $urandom;
            ws = ($urandom_range(4) == 0);
            ae = ($urandom_range(3) == 0);
            wv = $urandom;
            e_exp = m_rdy[i];
            spi_xfer(i, m, n, 0, ws, wv, ae, rx, e, l);
            if (ae) m_rdy[i] = 1'b0;
            m_frame(i, m, n, exp);
            if (ws) begin
                m_buf[i] = msk(i, wv);
                m_rsp[i] = 1'b1;
            end
            if (n == w_of(i)) begin
                total_cnt++;
                if (rx !== exp)
                    $display("FAIL rnd_miso[%0d] i=%0d got %h want %h", t, i, rx, exp);
                else pass_cnt++;
            end
            total_cnt++;
            if ({e, l, get_cmd(i)} !== {e_exp, m_rdy[i], m_cmd[i]})
                $display("FAIL rnd_cmd[%0d] i=%0d got %b%b/%h want %b%b/%h", t, i,
                         e, l, get_cmd(i), e_exp, m_rdy[i], m_cmd[i]);
            else pass_cnt++;
            total_cnt++;
            if ({ovr[i], und[i], rsp[i], oe[i]} !== {m_ovr[i], m_und[i], m_rsp[i], 1'b0})
                $display("FAIL rnd_flags[%0d] i=%0d got %b want %b", t, i,
                         {ovr[i], und[i], rsp[i], oe[i]},
                         {m_ovr[i], m_und[i], m_rsp[i], 1'b0});
            else pass_cnt++;
            total_cnt++;
            if (ferr_seen[i] !== m_ferr[i])
                $display("FAIL rnd_ferr[%0d] i=%0d got %0d want %0d", t, i,
                         ferr_seen[i], m_ferr[i]);
            else pass_cnt++;
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog timeout passed=%0d total=%0d", pass_cnt, total_cnt);
        $fatal(1, "timeout");
    end

    initial begin
        for (int k = 0; k < 3; k++) sclk[k] = cpol_of(k);
        ss_n = '1;
        mosi = '0;
        wrt = '0;
        ack = '0;
        clr = '0;
        tx0 = '0;
        tx1 = '0;
        tx2 = '0;
        m_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        test_reset();
        test_mode(0);
        test_mode(1);
        test_width();
        test_overrun();
        test_underrun();
        test_ack_commit();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/spi_slave_param.md
Name: spi_slave_param

Overview:
Parametrised SPI slave bridging an external SPI master to the digital core, replacing the fixed 16-bit single-mode slave. It supports configurable frame width, all four SPI modes, and a configurable synchroniser depth. It adds a cmd_rdy/cmd_ack handshake, a double-buffered response path, and frame-length, overrun and underrun error reporting. It sits between the resolver core command decoder and the chip SPI pins.

Parameters:
DATA_W, 16, frame width in bits (4..32)
CPOL, 0, SCLK idle level
CPHA, 1, 0 = sample on leading edge; 1 = sample on trailing edge
SYNC_STAGES, 2, synchroniser flops on SCLK/SS_n/MOSI (2..4)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
SCLK  in  1  SPI clock from master
SS_n  in  1  slave select, active low
MOSI  in  1  master-out data
MISO  out  1  slave-out data; high-Z when deselected
miso_oe  out  1  MISO drive enable
tx_data  in  DATA_W  response word from core
wrt  in  1  one-cycle strobe; writes tx_data into the response buffer
rsp_rdy  out  1  response buffer holds an unsent word
cmd_rcvd  out  DATA_W  last committed command word
cmd_rdy  out  1  cmd_rcvd valid, held until acknowledged
cmd_ack  in  1  core consumed cmd_rcvd
frame_err  out  1  one-cycle pulse: frame ended with bit count != DATA_W
overrun  out  1  sticky: a complete frame was dropped while cmd_rdy was high
underrun  out  1  sticky: a frame started with no pending response
clr_err  in  1  clears overrun and underrun

Behaviour:
- Reset values: MISO=Z, miso_oe=0, rsp_rdy=0, cmd_rcvd=0, cmd_rdy=0, frame_err=0, overrun=0, underrun=0, tx buffer=0, state=IDLE, armed=0. Sync flops reset to SCLK=CPOL, SS_n=1, MOSI=0.
- SCLK, SS_n and MOSI each pass through SYNC_STAGES flops. One extra SCLK flop provides edge detection.
- Leading edge = synchronised SCLK leaving CPOL; trailing edge = returning to CPOL.
- Sample edge = leading if CPHA=0, trailing if CPHA=1. Change edge = the other edge.
- Timing requirement: clk ≥ 8× SCLK frequency.
- armed is set when synchronised SS_n=1. This prevents starting mid-frame after reset.
- FSM IDLE:
  - On synchronised SS_n falling with armed=1, go to XFER.
  - On that transition, load shift_tx from the tx buffer, clear bit_cnt, and set miso_oe=1.
  - If rsp_rdy was 0, set underrun and send the stale buffer contents.
  - On the load, clear rsp_rdy.
- Simultaneous wrt and load: the shifter loads the old buffer contents; the new word is stored and rsp_rdy=1.
- XFER:
  - MISO = shift_tx[DATA_W-1].
  - On each sample edge: shift_rx <= {shift_rx, MOSI_sync}; bit_cnt increments, saturating at DATA_W+1.
  - On each change edge, shift_tx shifts left.
  - CPHA=1 exception: the first change (leading) edge does not shift, because the MSB is already presented.
  - On synchronised SS_n rising: miso_oe=0, go to IDLE, then evaluate:
    - bit_cnt != DATA_W: pulse frame_err for 1 clk; discard shift_rx.
    - bit_cnt == DATA_W and cmd_rdy=0: cmd_rcvd <= shift_rx; cmd_rdy=1 on the next clk.
    - bit_cnt == DATA_W and cmd_rdy=1: keep the old cmd_rcvd; set overrun.
- Latency: cmd_rdy rises SYNC_STAGES+2 clk edges after the SS_n pin rises.
- cmd_ack while cmd_rdy=1 clears cmd_rdy next clk.
- Commit and cmd_ack in the same cycle: ack clears, then the new word commits, so cmd_rdy stays 1 with the new data and no overrun.
- clr_err clears the sticky flags. If a set and clr_err occur in the same cycle, set wins.
- rst_n asserted mid-frame aborts the transfer. No commit and no frame_err. The bus is ignored until SS_n is seen high.

Test Plan:
- Mode 0 and mode 3 (CPOL=CPHA=0 and CPOL=CPHA=1), DATA_W=16: core writes 0xA5C3; master sends 0x1234 → cmd_rcvd=0x1234, cmd_rdy=1 at SYNC_STAGES+2 clk after SS_n rises; master receives 0xA5C3; rsp_rdy 1→0 at frame start.
- DATA_W=12, CPHA=0: 12-bit frame 0xABC → cmd_rcvd=0xABC; a 13-bit frame → frame_err pulse, cmd_rdy unchanged.
- Overrun: two 0x00FF/0xFF00 frames with no cmd_ack → cmd_rcvd=0x00FF, overrun=1; after clr_err → overrun=0.
- Underrun: frame with no wrt → underrun=1 and the previous buffer word is transmitted. wrt landing on the same cycle as frame start → old word sent, rsp_rdy=1 afterwards.
- Reset mid-frame after 7 bits with SS_n held low → no cmd_rdy. The next frame after SS_n goes high then low is received correctly.
- MISO=Z whenever SS_n is high. cmd_ack and commit in the same cycle → cmd_rdy stays 1 with the new word.
